// File: rtl/if_prefetch_queue16.sv
// Instruction prefetch unit: issues in-order fetches, buffers {ir, npc} in a
// circular queue toward ID, and flushes/discards stale words on redirect.
module if_prefetch_queue16 #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter int          AW       = 10,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic          clk1,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic          imem_rvalid,
  input  logic [15:0]   imem_rdata,
  input  logic          redirect_valid,
  input  logic [15:0]   redirect_pc,
  input  logic          halt,
  output logic          id_valid,
  output logic [15:0]   id_ir,
  output logic [15:0]   id_npc,
  input  logic          id_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int SW = CW + OW;

  logic [15:0]   pc_q, pc_d;
  logic          imem_req_q, imem_req_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [15:0] ir_mem_q  [DEPTH];
  logic [15:0] npc_mem_q [DEPTH];
  logic [15:0] tag_mem_q [MAX_OUT];

  logic          acc, rsp, push, pop, credit;
  logic [SW-1:0] oblig;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    acc  = imem_req_q && imem_ready;
    rsp  = imem_rvalid && (out_q != '0);
    pop  = (cnt_q != '0) && id_ready && !redirect_valid;
    push = rsp && (drop_q == '0) && !redirect_valid;

    out_d    = out_q + OW'(acc) - OW'(rsp);
    drop_d   = (rsp && (drop_q != '0)) ? drop_q - 1'b1 : drop_q;
    tag_wr_d = acc ? tag_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d = rsp ? tag_inc(tag_rd_q) : tag_rd_q;
    pc_d     = acc ? pc_q + 16'd1 : pc_q;
    wr_d     = wr_q + PW'(push);
    rd_d     = rd_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    // Pops are not credited; accepts and kept responses this cycle are,
    // so count + out can never exceed DEPTH and out never exceeds MAX_OUT.
    oblig    = SW'(cnt_q) + SW'(push) + SW'(out_d);

    if (redirect_valid) begin
      pc_d   = redirect_pc;
      drop_d = out_d;
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
      oblig  = SW'(out_d);
    end

    credit = (oblig < SW'(DEPTH)) && (out_d < OW'(MAX_OUT));

    if (imem_req_q && !imem_ready && !redirect_valid) begin
      imem_req_d  = 1'b1;
      imem_addr_d = imem_addr_q;
    end else begin
      imem_req_d  = !halt && credit;
      imem_addr_d = imem_req_d ? pc_d[AW-1:0] : imem_addr_q;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      out_q       <= '0;
      drop_q      <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      tag_rd_q    <= '0;
      tag_wr_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      tag_rd_q    <= tag_rd_d;
      tag_wr_q    <= tag_wr_d;
    end
  end

  // Storage carries data only; validity is tracked by the control state above.
  always_ff @(posedge clk1) begin
    if (push) begin
      ir_mem_q[wr_q]  <= imem_rdata;
      npc_mem_q[wr_q] <= tag_mem_q[tag_rd_q];
    end
    if (acc) begin
      tag_mem_q[tag_wr_q] <= pc_q + 16'd1;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign id_valid  = (cnt_q != '0);
  assign id_ir     = id_valid ? ir_mem_q[rd_q]  : 16'h0000;
  assign id_npc    = id_valid ? npc_mem_q[rd_q] : 16'h0000;

endmodule

// File: tb/tb_if_prefetch_queue16.sv
// Bench for if_prefetch_queue16: cycle vector table plus memory-model driven
// sequences for latency, redirect, halt, address wrap and mid-stall reset.
module tb_if_prefetch_queue16;

  logic        clk1;
  logic        reset;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        id_valid;
  logic [15:0] id_ir;
  logic [15:0] id_npc;
  logic        id_ready;

  if_prefetch_queue16 #(
    .DEPTH(4), .MAX_OUT(2), .AW(10), .RESET_PC(16'h0000)
  ) dut (
    .clk1(clk1), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .id_valid(id_valid), .id_ir(id_ir), .id_npc(id_npc), .id_ready(id_ready)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    logic        rdy;
    logic        hlt;
    logic        rv;
    logic [15:0] rpc;
    logic        e_req;
    logic [9:0]  e_addr;
    logic        e_vld;
    logic [15:0] e_ir;
    logic [15:0] e_npc;
  } vec_t;

  typedef struct {
    logic [9:0] addr;
    int         due;
  } pend_t;

  localparam int NV = 29;
  localparam int MAXO = 2;

  vec_t        tbl [NV];
  pend_t       pend [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_due = 0;
  int          rdy_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic [15:0] exp_pc;
  logic [15:0] exp_issue;
  logic        prev_hold;
  logic [9:0]  prev_addr;

  function automatic vec_t mk(logic rdy, logic hlt, logic rv, logic [15:0] rpc,
                              logic req, logic [9:0] addr, logic vld,
                              logic [15:0] ir, logic [15:0] npc);
    vec_t v;
    v.rdy = rdy; v.hlt = hlt; v.rv = rv; v.rpc = rpc;
    v.e_req = req; v.e_addr = addr; v.e_vld = vld; v.e_ir = ir; v.e_npc = npc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0000;
    redirect_valid = 1'b0; redirect_pc = 16'h0000; halt = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    reset = 1'b0;
    pend.delete();
    last_due  = 0;
    exp_pc    = 16'h0000;
    exp_issue = 16'h0000;
    prev_hold = 1'b0;
  endtask

  // One clock cycle: sample at negedge, drive inputs and memory model, advance.
  task automatic step(input logic rdy_id, input logic hlt, input logic rv, input logic [15:0] rpc);
    int lat;
    int d;
    pend_t p;
    if (prev_hold)
      check("hold_stable", {imem_req, imem_addr}, {1'b1, prev_addr});
    id_ready = rdy_id; halt = hlt; redirect_valid = rv; redirect_pc = rpc;
    imem_ready  = ($urandom_range(99) < rdy_pct);
    imem_rvalid = 1'b0;
    imem_rdata  = 16'hDEAD;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'h1000 + {6'b0, pend[0].addr};
      void'(pend.pop_front());
    end
    if (id_valid && id_ready && !rv) begin
      check("deliver", {id_ir, id_npc}, {16'h1000 + {6'b0, exp_pc[9:0]}, exp_pc + 16'd1});
      exp_pc = exp_pc + 16'd1;
    end
    if (imem_req && imem_ready) begin
      check("issue_addr", 64'(imem_addr), 64'(exp_issue[9:0]));
      exp_issue = exp_issue + 16'd1;
      lat = $urandom_range(lat_max, lat_min);
      d = cyc + lat;
      if (d < last_due + 1) d = last_due + 1;
      last_due = d;
      p.addr = imem_addr;
      p.due  = d;
      pend.push_back(p);
      check("outstanding_limit", 64'(pend.size() <= MAXO), 64'd1);
    end
    if (rv) begin
      exp_pc    = rpc;
      exp_issue = rpc;
    end
    prev_hold = imem_req && !imem_ready && !rv;
    prev_addr = imem_addr;
    @(posedge clk1);
    cyc++;
    @(negedge clk1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [15:0] pc0;

    //            rdy hlt rv rpc       req addr   vld ir        npc
    tbl[0]  = mk(1, 0, 0, 16'h0000, 0, 10'h000, 0, 16'h0000, 16'h0000);
    tbl[1]  = mk(1, 0, 0, 16'h0000, 1, 10'h000, 0, 16'h0000, 16'h0000);
    tbl[2]  = mk(1, 0, 0, 16'h0000, 1, 10'h001, 0, 16'h0000, 16'h0000);
    tbl[3]  = mk(1, 0, 0, 16'h0000, 1, 10'h002, 1, 16'h1000, 16'h0001);
    tbl[4]  = mk(1, 0, 0, 16'h0000, 1, 10'h003, 1, 16'h1001, 16'h0002);
    tbl[5]  = mk(1, 0, 0, 16'h0000, 1, 10'h004, 1, 16'h1002, 16'h0003);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 1, 10'h005, 1, 16'h1003, 16'h0004);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 1, 10'h006, 1, 16'h1003, 16'h0004);
    tbl[8]  = mk(0, 0, 0, 16'h0000, 0, 10'h006, 1, 16'h1003, 16'h0004);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 0, 10'h006, 1, 16'h1003, 16'h0004);
    tbl[10] = mk(0, 0, 0, 16'h0000, 0, 10'h006, 1, 16'h1003, 16'h0004);
    tbl[11] = mk(0, 0, 0, 16'h0000, 0, 10'h006, 1, 16'h1003, 16'h0004);
    tbl[12] = mk(1, 0, 0, 16'h0000, 0, 10'h006, 1, 16'h1003, 16'h0004);
    tbl[13] = mk(1, 0, 0, 16'h0000, 0, 10'h006, 1, 16'h1004, 16'h0005);
    tbl[14] = mk(1, 0, 0, 16'h0000, 1, 10'h007, 1, 16'h1005, 16'h0006);
    tbl[15] = mk(1, 0, 0, 16'h0000, 1, 10'h008, 1, 16'h1006, 16'h0007);
    tbl[16] = mk(1, 0, 0, 16'h0000, 1, 10'h009, 1, 16'h1007, 16'h0008);
    tbl[17] = mk(1, 0, 1, 16'h0020, 1, 10'h00A, 1, 16'h1008, 16'h0009);
    tbl[18] = mk(1, 0, 0, 16'h0000, 1, 10'h020, 0, 16'h0000, 16'h0000);
    tbl[19] = mk(1, 0, 0, 16'h0000, 1, 10'h021, 0, 16'h0000, 16'h0000);
    tbl[20] = mk(1, 0, 0, 16'h0000, 1, 10'h022, 1, 16'h1020, 16'h0021);
    tbl[21] = mk(1, 0, 0, 16'h0000, 1, 10'h023, 1, 16'h1021, 16'h0022);
    tbl[22] = mk(1, 1, 0, 16'h0000, 1, 10'h024, 1, 16'h1022, 16'h0023);
    tbl[23] = mk(1, 1, 0, 16'h0000, 0, 10'h024, 1, 16'h1023, 16'h0024);
    tbl[24] = mk(1, 1, 0, 16'h0000, 0, 10'h024, 1, 16'h1024, 16'h0025);
    tbl[25] = mk(1, 0, 0, 16'h0000, 0, 10'h024, 0, 16'h0000, 16'h0000);
    tbl[26] = mk(1, 0, 0, 16'h0000, 1, 10'h025, 0, 16'h0000, 16'h0000);
    tbl[27] = mk(1, 0, 0, 16'h0000, 1, 10'h026, 0, 16'h0000, 16'h0000);
    tbl[28] = mk(1, 0, 0, 16'h0000, 1, 10'h027, 1, 16'h1025, 16'h0026);

    // Cycle table with a 1-cycle, always-ready memory
    do_reset();
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    for (int k = 0; k < NV; k++) begin
      check($sformatf("vec%0d", k),
            64'({imem_req, imem_addr, id_valid, id_ir, id_npc}),
            64'({tbl[k].e_req, tbl[k].e_addr, tbl[k].e_vld, tbl[k].e_ir, tbl[k].e_npc}));
      step(tbl[k].rdy, tbl[k].hlt, tbl[k].rv, tbl[k].rpc);
    end

    // Random latency 1..5 with random accept stalls and ID backpressure
    do_reset();
    rdy_pct = 70; lat_min = 1; lat_max = 5;
    for (int k = 0; k < 400; k++)
      step($urandom_range(3) != 0, 1'b0, 1'b0, 16'h0000);
    check("random_progress", 64'(exp_pc > 16'd30), 64'd1);

    // Redirect with two requests in flight and a non-empty queue
    do_reset();
    rdy_pct = 100; lat_min = 3; lat_max = 3;
    n = 0;
    while (!(pend.size() == 2 && id_valid) && n < 50) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      n++;
    end
    check("redir_setup", 64'(pend.size() == 2 && id_valid), 64'd1);
    step(1'b0, 1'b0, 1'b1, 16'h0020);
    check("redir_flush_valid", 64'(id_valid), 64'd0);
    n = 0;
    while (exp_pc != 16'h0022 && n < 60) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      n++;
    end
    check("redir_target_delivered", 64'(exp_pc), 64'h0022);

    // Halt mid-stream: no new requests, queue drains, resume at correct PC
    do_reset();
    rdy_pct = 100; lat_min = 2; lat_max = 2;
    repeat (10) step(1'b1, 1'b0, 1'b0, 16'h0000);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (k >= 1 && imem_req) bad++;
      step(1'b1, 1'b1, 1'b0, 16'h0000);
    end
    check("halt_no_req", 64'(bad), 64'd0);
    check("halt_drained", 64'({id_valid, pend.size() == 0}), 64'b01);
    pc0 = exp_pc;
    n = 0;
    while (exp_pc != pc0 + 16'd3 && n < 20) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      n++;
    end
    check("halt_resume", 64'(exp_pc), 64'(pc0 + 16'd3));

    // PC crossing 0x03FF: address wraps to 0, npc continues to 0x0400
    do_reset();
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    step(1'b1, 1'b0, 1'b1, 16'h03FE);
    n = 0;
    while (exp_pc != 16'h0402 && n < 20) begin
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      n++;
    end
    check("wrap_delivered", 64'(exp_pc), 64'h0402);

    // Reset asserted while a request is held by the memory
    do_reset();
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000);
    rdy_pct = 0;
    repeat (2) step(1'b0, 1'b1, 1'b0, 16'h0000);
    check("pre_reset_busy", 64'({id_valid, imem_req}), 64'b11);
    reset = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; halt = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    check("reset_mid_stall", 64'({imem_req, imem_addr, id_valid, id_ir, id_npc}), 64'd0);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
